// File: rtl/irq_pending_4_if.sv
// Bus bundle for the four-channel request capture stage.
// The master side drives capture controls; the slave side (the capture stage) returns the pending state.
interface irq_pending_4_if;
  logic       enable;
  logic [3:0] req_in;
  logic [3:0] mask;
  logic       ack;
  logic [1:0] ack_idx;
  logic       ovr_clr;
  logic [3:0] pending;
  logic [3:0] raw_pending;
  logic [3:0] overrun;
  logic       any_pending;

  modport master (
    output enable, req_in, mask, ack, ack_idx, ovr_clr,
    input  pending, raw_pending, overrun, any_pending
  );

  modport slave (
    input  enable, req_in, mask, ack, ack_idx, ovr_clr,
    output pending, raw_pending, overrun, any_pending
  );
endinterface

// File: rtl/irq_pending_4.sv
// Four-channel request capture: synchronise, detect rising edges, and latch them as sticky pending bits
// with overrun tracking. Output is the masked pending vector that feeds the downstream priority encoder.
module irq_pending_4 #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  irq_pending_4_if.slave  bus
);

  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] prev_q;
  logic [3:0] raw_q;
  logic [3:0] ovr_q;
  logic [3:0] raw_d;
  logic [3:0] ovr_d;
  logic [3:0] rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
      raw_q  <= '0;
      ovr_q  <= '0;
    end else begin
      sync_q[0] <= bus.req_in;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      // History tracks the line even while capture is disabled, so a level
      // that rose during enable=0 never produces a late edge.
      prev_q <= sync_q[SYNC_STAGES-1];
      raw_q  <= raw_d;
      ovr_q  <= ovr_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_comb begin
    raw_d = raw_q;
    ovr_d = ovr_q;
    for (int unsigned i = 0; i < 4; i++) begin
      logic set_i;
      logic clr_i;
      set_i = rise[i] & bus.enable;
      clr_i = bus.ack & (bus.ack_idx == 2'(i));
      // A new event wins over a same-cycle ack, and is not an overrun.
      if (set_i) begin
        raw_d[i] = 1'b1;
      end else if (clr_i) begin
        raw_d[i] = 1'b0;
      end
      if (set_i && raw_q[i] && !clr_i) begin
        ovr_d[i] = 1'b1;
      end else if (bus.ovr_clr) begin
        ovr_d[i] = 1'b0;
      end
    end
  end

  assign bus.raw_pending = raw_q;
  assign bus.overrun     = ovr_q;
  assign bus.pending     = raw_q & ~bus.mask;
  assign bus.any_pending = |(raw_q & ~bus.mask);

endmodule

// File: doc/irq_pending_4.md
Name: irq_pending_4

Overview:
- Four-channel request capture stage that sits directly upstream of the 4-input priority encoder.
- Synchronises four asynchronous request lines and detects rising edges on them.
- Latches each edge into a sticky pending bit and presents the masked pending vector to the encoder's in[3:0] input.
- Clears a pending bit when the consumer acknowledges that channel's index, which is the encoder's out[1:0], and flags overruns when a new edge arrives on a channel whose bit is still pending.

Parameters:
SYNC_STAGES, 2, number of synchroniser flip-flops per request line; legal range 2..4.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
enable  input  1  capture enable; when 0, no new edges are latched
req_in  input  4  asynchronous request lines, one per channel
mask  input  4  synchronous per-channel mask; 1 hides the channel from pending
ack  input  1  single-cycle acknowledge strobe
ack_idx  input  2  index of the channel being acknowledged
ovr_clr  input  1  single-cycle strobe that clears all overrun bits
pending  output  4  raw_pending AND NOT mask; feeds the encoder's in[3:0]
raw_pending  output  4  unmasked sticky pending bits, registered
overrun  output  4  sticky per-channel overrun flags, registered
any_pending  output  1  OR of pending; combinational from registered raw_pending and mask

Behaviour:
- Reset (rst_n low, asynchronous assert, synchronous release by clk):
  - All synchroniser flip-flops, edge-history flip-flops, raw_pending and overrun go to 0.
  - pending and any_pending therefore read 0 while reset is low.
- Synchroniser: each req_in bit passes through a chain of SYNC_STAGES flip-flops. sync[i] is the last stage of that chain.
- Edge detect: prev[i] is a register holding sync[i] from the previous cycle. A rise on channel i is defined as sync[i]=1 and prev[i]=0.
- The prev register always updates, regardless of enable. Consequence: a line that rose while enable=0 does not produce an edge later when enable returns to 1.
- Capture latency with SYNC_STAGES=2: req_in rises between clock edges 0 and 1; raw_pending[i] reads 1 after edge 3. In general the bit is set after edge SYNC_STAGES+1.
- Per-channel next-state, evaluated each cycle in this priority order:
  1. set_i = rise_i AND enable. clr_i = ack AND (ack_idx==i).
  2. If set_i and raw_pending[i] is already 1 and clr_i is 0: raw_pending[i] stays 1 and overrun[i] goes to 1.
  3. If set_i and clr_i are both 1 in the same cycle: raw_pending[i] = 1, no overrun. The new event survives the ack.
  4. Otherwise, if set_i: raw_pending[i] = 1.
  5. Otherwise, if clr_i: raw_pending[i] = 0.
  6. Otherwise: raw_pending[i] holds.
- overrun:
  - Sticky until ovr_clr.
  - If ovr_clr and a new overrun occur in the same cycle, the new overrun wins and that bit stays 1. All other bits clear.
- Ack to a channel whose raw_pending bit is 0 is ignored; no flag is raised.
- Ack to a masked channel still clears its raw_pending bit.
- mask:
  - Affects only the pending and any_pending outputs.
  - Capture continues while masked. Unmasking exposes a bit captured while masked on the same cycle; no register delay.
- enable=0:
  - Blocks capture only.
  - Existing pending bits are held and can still be acknowledged.
  - The overrun and ovr_clr logic still operate.
- Input widths: req_in, mask, pending, raw_pending and overrun are 4 bits; ack_idx is 2 bits. Every ack_idx value is legal.
- Reset asserted mid-operation clears all state immediately, independent of clk. The first edge can be captured no earlier than SYNC_STAGES+1 clocks after release.
- A level held high on req_in produces exactly one edge; the line must return low, and be seen low, before another rise is detected.

Test Plan:
- Reset, enable=1, mask=0, raise req_in=4'b0100 between edges 0 and 1 -> raw_pending=4'b0000 after edges 1 and 2; raw_pending=4'b0100 after edge 3; pending=4'b0100; any_pending=1.
- pending=4'b1010; pulse ack with ack_idx=3 for one cycle -> pending=4'b0010 on the next cycle; then ack with ack_idx=0 -> pending stays 4'b0010.
- Channel 1 pending, second rise on req_in[1] synchronised with no ack -> overrun=4'b0010 and raw_pending[1]=1; pulse ovr_clr -> overrun=4'b0000.
- Channel 2 pending; synchronised rise on channel 2 arrives in the same cycle as ack with ack_idx=2 -> raw_pending[2]=1 and overrun[2]=0.
- enable=0, rise req_in[0] and hold it high, then set enable=1 -> raw_pending[0] stays 0; drop req_in[0], raise it again -> raw_pending[0]=1 three edges later.
- mask=4'b1111, rise req_in=4'b1001 -> raw_pending=4'b1001, pending=4'b0000, any_pending=0; set mask=0 -> pending=4'b1001 the same cycle; assert rst_n=0 mid-cycle -> all outputs 0 immediately.
